// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a framed, checksummed byte stream into instruction memory and releases the core
module imem_boot_loader #(
    parameter int          ADDR_W    = 10,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              globalclock,
    input  logic              globalreset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error
);
    typedef enum logic [2:0] {WAIT_SYNC, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR} state_t;

    state_t            state, state_n;
    logic [15:0]       len;
    logic [7:0]        csum;
    logic [31:0]       asm_word;
    logic [1:0]        bcnt;
    logic [ADDR_W-1:0] widx;
    logic              fire;
    logic [15:0]       len_n;
    logic              too_big;
    logic              last_word;

    assign fire      = rx_valid && rx_ready;
    assign len_n     = {len[15:8], rx_data};
    assign too_big   = 32'(len_n) > (32'd1 << ADDR_W);
    assign last_word = 16'(widx) == len - 16'd1;

    // state register
    always_ff @(posedge globalclock or negedge globalreset) begin
        if (!globalreset) state <= WAIT_SYNC;
        else              state <= state_n;
    end

    // next-state decode; only an accepted byte can move the FSM
    always_comb begin
        state_n = state;
        if (fire) begin
            case (state)
                WAIT_SYNC, ERR: state_n = (rx_data == SYNC_BYTE) ? LEN_HI : state;
                LEN_HI:         state_n = LEN_LO;
                LEN_LO:         state_n = too_big ? ERR : (len_n == 16'd0 ? CSUM : DATA);
                DATA:           state_n = (bcnt == 2'd3 && last_word) ? CSUM : DATA;
                CSUM:           state_n = (rx_data == csum) ? DONE : ERR;
                default:        state_n = state;
            endcase
        end
    end

    // datapath and registered outputs; status flags follow the state being entered
    always_ff @(posedge globalclock or negedge globalreset) begin
        if (!globalreset) begin
            len        <= '0;
            csum       <= '0;
            asm_word   <= '0;
            bcnt       <= '0;
            widx       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            rx_ready   <= 1'b1;
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we    <= 1'b0;
            rx_ready   <= state_n != DONE;
            core_reset <= state_n != DONE;
            done       <= state_n == DONE;
            error      <= state_n == ERR;
            if (fire) begin
                case (state)
                    WAIT_SYNC, ERR: begin
                        if (rx_data == SYNC_BYTE) begin
                            csum <= '0;
                            widx <= '0;
                            bcnt <= '0;
                        end
                    end
                    LEN_HI: len[15:8] <= rx_data;
                    LEN_LO: len[7:0]  <= rx_data;
                    DATA: begin
                        asm_word <= {asm_word[23:0], rx_data};
                        csum     <= csum ^ rx_data;
                        bcnt     <= bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= widx;
                            imem_wdata <= {asm_word[23:0], rx_data};
                            widx       <= widx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
